// File: rtl/logic_wb_stage.sv
// Write-back stage for the logical unit: aligns issue tags with late results, queues them in a FIFO,
// drains to the register file and offers youngest-match operand forwarding.
module logic_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [ADDR_W-1:0]          issue_rd,
  input  logic [DATA_W-1:0]          logical_value,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [ADDR_W-1:0]          wb_rd,
  output logic [DATA_W-1:0]          wb_data,
  input  logic [ADDR_W-1:0]          byp_addr,
  output logic                       byp_hit,
  output logic [DATA_W-1:0]          byp_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  byp_idx;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_rd;
  logic              accept;
  logic              push;
  logic              pop;

  // Credit check covers the in-flight slot so a push can never hit a full FIFO.
  assign issue_ready = ({1'b0, count} + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(DEPTH);
  assign accept      = issue_valid && issue_ready;
  assign push        = inflight && (inflight_rd != '0);
  assign pop         = wb_valid && wb_ready;

  assign wb_valid = (count != '0);
  assign wb_rd    = wb_valid ? rd_mem[rd_ptr]   : '0;
  assign wb_data  = wb_valid ? data_mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_rd <= '0;
    end else begin
      inflight    <= accept;
      inflight_rd <= issue_rd;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= inflight_rd;
      data_mem[wr_ptr] <= logical_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && count == CNT_W'(DEPTH)));
  end

  // Oldest-to-newest scan so later matches win; the in-flight result is youngest of all.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = '0;
    if (byp_addr != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        byp_idx = rd_ptr + PTR_W'(i);
        if ((CNT_W'(i) < count) && (rd_mem[byp_idx] == byp_addr)) begin
          byp_hit  = 1'b1;
          byp_data = data_mem[byp_idx];
        end
      end
      if (inflight && (inflight_rd == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = logical_value;
      end
    end
  end

endmodule

// File: tb/tb_logic_wb_stage.sv
// Randomized and directed bench for logic_wb_stage against a queue-based reference model.
module tb_logic_wb_stage;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic [31:0] logical_value;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  byp_addr;
  logic        byp_hit;
  logic [31:0] byp_data;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      mq[$];
  logic        m_infl;
  logic [4:0]  m_rd;
  int          n_cmp;
  int          n_err;

  logic_wb_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .logical_value(logical_value),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against what the model says the stage currently holds.
  task automatic compare_model();
    int          sz;
    logic        e_hit;
    logic [31:0] e_data;
    sz     = mq.size();
    e_hit  = 1'b0;
    e_data = '0;
    if (byp_addr != 5'd0) begin
      if (m_infl && m_rd == byp_addr) begin
        e_hit  = 1'b1;
        e_data = logical_value;
      end else begin
        for (int i = sz - 1; i >= 0; i--) begin
          if (mq[i].rd == byp_addr) begin
            e_hit  = 1'b1;
            e_data = mq[i].data;
            break;
          end
        end
      end
    end
    check("count",       64'(count),       64'(sz));
    check("wb_valid",    64'(wb_valid),    64'(sz != 0));
    check("wb_rd",       64'(wb_rd),       (sz != 0) ? 64'(mq[0].rd) : 64'd0);
    check("wb_data",     64'(wb_data),     (sz != 0) ? 64'(mq[0].data) : 64'd0);
    check("issue_ready", 64'(issue_ready), 64'((sz + int'(m_infl)) < 4));
    check("byp_hit",     64'(byp_hit),     64'(e_hit));
    check("byp_data",    64'(byp_data),    64'(e_data));
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird, input logic [31:0] lv,
                       input logic wr, input logic [4:0] ba);
    @(negedge clk);
    issue_valid   = iv;
    issue_rd      = ird;
    logical_value = lv;
    wb_ready      = wr;
    byp_addr      = ba;
    #1;
    compare_model();
  endtask

  // Advance the model by one clock using the inputs currently applied, then take the edge.
  task automatic tick();
    logic acc;
    logic popv;
    acc  = issue_valid && ((mq.size() + int'(m_infl)) < 4);
    popv = (mq.size() != 0) && wb_ready;
    if (reset) begin
      mq.delete();
      m_infl = 1'b0;
      m_rd   = '0;
    end else begin
      if (popv) void'(mq.pop_front());
      if (m_infl && m_rd != 5'd0) mq.push_back('{rd: m_rd, data: logical_value});
      m_infl = acc;
      m_rd   = issue_rd;
    end
    @(posedge clk);
  endtask

  task automatic step(input logic iv, input logic [4:0] ird, input logic [31:0] lv,
                      input logic wr, input logic [4:0] ba);
    drive(iv, ird, lv, wr, ba);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_infl = 1'b0;
    m_rd = '0;
    reset = 1'b1;
    issue_valid = 1'b0;
    issue_rd = '0;
    logical_value = '0;
    wb_ready = 1'b0;
    byp_addr = '0;

    // Reset state while reset is held
    drive(1'b0, 5'd0, 32'h1234_5678, 1'b0, 5'd3);
    check("rst_ready", 64'(issue_ready), 64'd1);
    tick();
    #2 reset = 1'b0;

    // Single op: two-cycle latency, one-cycle presentation
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd0);
    step(1'b0, 5'd0, 32'hA5A5_0F0F, 1'b1, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    check("single_valid", 64'(wb_valid), 64'd1);
    check("single_rd",    64'(wb_rd),    64'd5);
    check("single_data",  64'(wb_data),  64'hA5A5_0F0F);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check("single_gone", 64'(wb_valid), 64'd0);
    tick();

    // Fill with no write-back: four accepts then back-pressure
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'(k + 1), 32'(k * 16 + 3), 1'b0, 5'd0);
      check("fill_ready", 64'(issue_ready), (k < 4) ? 64'd1 : 64'd0);
      tick();
    end
    drive(1'b1, 5'd9, 32'd0, 1'b0, 5'd0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_stall", 64'(issue_ready), 64'd0);
    tick();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("fill_release", 64'(issue_ready), 64'd1);
    tick();
    drain();

    // x0 discard
    step(1'b1, 5'd0, 32'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
    check("x0_byp_hit", 64'(byp_hit), 64'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check("x0_count", 64'(count), 64'd0);
    check("x0_valid", 64'(wb_valid), 64'd0);
    tick();

    // Bypass ordering, youngest first
    step(1'b1, 5'd7, 32'd0, 1'b0, 5'd7);
    step(1'b1, 5'd7, 32'h1, 1'b0, 5'd7);
    step(1'b1, 5'd7, 32'h2, 1'b0, 5'd7);
    drive(1'b0, 5'd0, 32'h3, 1'b0, 5'd7);
    check("byp_inflight", 64'(byp_data), 64'h3);
    tick();
    drive(1'b0, 5'd0, 32'h55, 1'b1, 5'd7);
    check("byp_pushed", 64'(byp_data), 64'h3);
    check("byp_head", 64'(wb_data), 64'h1);
    tick();
    drive(1'b0, 5'd0, 32'h66, 1'b0, 5'd7);
    check("byp_popped", 64'(byp_data), 64'h3);
    tick();
    drain();

    // Simultaneous push and pop at count 2
    step(1'b1, 5'd11, 32'd0, 1'b0, 5'd0);
    step(1'b1, 5'd12, 32'hB1, 1'b0, 5'd0);
    step(1'b1, 5'd13, 32'hB2, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'hB3, 1'b1, 5'd0);
    check("pp_before", 64'(count), 64'd2);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("pp_after", 64'(count), 64'd2);
    tick();
    drain();

    // Ten ops through the pointer wrap
    for (int k = 0; k < 10; k++) step(1'b1, 5'(k + 1), 32'(k * 7 + 100), 1'b1, 5'(k));
    drain();

    // Asynchronous reset mid-cycle with three entries queued
    step(1'b1, 5'd21, 32'd0, 1'b0, 5'd0);
    step(1'b1, 5'd22, 32'hC1, 1'b0, 5'd0);
    step(1'b1, 5'd23, 32'hC2, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'hC3, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd22);
    check("pre_rst_count", 64'(count), 64'd3);
    reset = 1'b1;
    mq.delete();
    m_infl = 1'b0;
    #1;
    check("rst_valid", 64'(wb_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    compare_model();
    tick();
    #2 reset = 1'b0;
    drive(1'b0, 5'd0, 32'hEEEE_EEEE, 1'b1, 5'd22);
    check("post_rst_hit", 64'(byp_hit), 64'd0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
